alu_issue: RTL
==============

// Module: alu_issue
// PURPOSE
//  Command initiator for the single-cycle alu: accepts register-based ops (cmd, rs1, rs2, rd) over valid/ready.
//  Reads operands from a local register file and drives the alu operand/command inputs.
//  Waits out the alu READY->BUSY->READY handshake, writes the result back to rd and reports completion.
//  Sits between the instruction front end and the alu; one op in flight at a time.
// PARAMETERS
//  NREGS   8   number of 32-bit registers in the local register file
//  ADDR_W  3   register index width; must equal clog2(NREGS)
// PORTS
//  clk          in   1       single clock, all state on posedge
//  reset        in   1       synchronous, active-high
//  i_req_valid  in   1       request present
//  o_req_ready  out  1       request accepted when valid && ready
//  i_req_cmd    in   3       alu opcode (NOP/SHL/SHR/SHRA/ADD/SUB/MUL/DIV = 0..7)
//  i_req_rs1    in   ADDR_W  operand A register
//  i_req_rs2    in   ADDR_W  operand B register
//  i_req_rd     in   ADDR_W  destination register
//  i_wr_en      in   1       external register load strobe
//  i_wr_addr    in   ADDR_W  external load index
//  i_wr_data    in   32      external load data
//  o_alu_a      out  32      to alu i_a
//  o_alu_b      out  32      to alu i_b
//  o_alu_cmd    out  3       to alu i_cmd
//  i_alu_result in   32      from alu o_result
//  i_alu_valid  in   1       from alu o_valid
//  i_alu_ready  in   1       from alu o_ready
//  o_done       out  1       one-cycle pulse: op retired
//  o_done_rd    out  ADDR_W  rd of retired op
//  o_done_data  out  32      result written to rd
// BEHAVIOUR
//  Reset: state IDLE; register file all 0; o_done=0, o_done_rd=0, o_done_data=0; o_alu_a/b=0, o_alu_cmd=3'b000.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE; o_req_ready = (state==IDLE) && !reset.
//  IDLE: on i_req_valid, latch cmd, rd, regfile[rs1], regfile[rs2] into operand regs; -> ISSUE.
//  ISSUE: drive latched operands/cmd; if i_alu_ready -> WAIT (alu samples at this edge); else stay.
//  WAIT: operands/cmd held stable. Capture only when i_alu_ready && i_alu_valid.
//   Capture edge: regfile[rd] <= i_alu_result; o_done <= 1; o_done_rd/o_done_data updated; -> IDLE.
//   i_alu_valid is sticky in the alu; it is never used alone as a completion signal.
//  o_done is high exactly one cycle; o_done_rd/o_done_data hold until the next retire.
//  Latency with an always-ready alu: accept edge T0, issue edge T1, alu BUSY cycle, capture edge T3.
//   o_done is high in the cycle after T3. Next accept is possible in that same cycle.
//  IDLE drives o_alu_cmd=NOP and o_alu_a/b=0.
//  Arithmetic: result is the 32-bit alu output, unmodified; SUB negation and MUL truncation are done by the alu.
//  External write: i_wr_en writes regfile[i_wr_addr] at the edge, in any state.
//  Write collisions:
//   - Capture and i_wr_en to the same index in one cycle: capture wins.
//   - Accept and i_wr_en to rs1/rs2 in one cycle: operands take the pre-write (old) value.
//   - rs1==rs2==rd is legal: operands are latched before writeback.
//  Reset in any state, including mid-WAIT, aborts the op with no writeback and no o_done.
//   The alu holds o_ready low during reset; ISSUE waits for it to return high.
// CONFIGURATION
//  ALU_ISSUE_R0_ZERO_EN defined:
//   - regfile[0] always reads 0.
//   - Writes to index 0 (capture or i_wr_en) are dropped.
//   - o_done still pulses, with o_done_data = alu result.
//  ALU_ISSUE_R0_ZERO_EN undefined: r0 is an ordinary register.
// TESTING
//  T1: load r1=5, r2=3; ADD rd=3 -> o_done 4 cycles after accept, o_done_rd=3, o_done_data=8, r3=8.
//  T2: r1=5, r2=3; SUB rd=4 -> data=2. SHL r1=1, r2=4 -> data=16.
//   DIV r1=100, r2=7 -> data=14. MUL 0x10000*0x10000 -> data=0.
//  T3: i_req_valid held high with 3 queued ops -> accept every 4 cycles; o_req_ready low outside IDLE.
//   Retire order matches request order.
//  T4: force i_alu_ready=0 for 5 cycles in ISSUE -> FSM stays in ISSUE with o_alu_* stable.
//   Proceeds 1 cycle after ready returns.
//  T5: assert reset during WAIT -> no o_done, rd unchanged, all registers read 0.
//   o_req_ready=1 the cycle after reset drops.
//  T6: ALU_ISSUE_R0_ZERO_EN on: i_wr_en r0=9, ADD r0+r0 -> rd=r5 gets 0, o_done_data=0.
//   Macro off: the same sequence gives 18.

Source files
------------

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//   Command initiator for the single-cycle alu. It accepts one register-based
//   op (cmd, rs1, rs2, rd) at a time, reads both operands from a local
//   register file and drives them, with the opcode, onto the alu inputs. It
//   then follows the alu READY -> BUSY -> READY handshake, writes the result
//   back to rd and pulses o_done.
//
// Parameters
//   NREGS   number of 32-bit registers in the local register file
//   ADDR_W  register index width, equal to clog2(NREGS)
//
// Ports
//   clk, reset           single clock; synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_cmd/rs1/rs2/rd   op request
//   i_wr_en/i_wr_addr/i_wr_data                      external register load
//   o_alu_a/o_alu_b/o_alu_cmd                        alu operand/command
//   i_alu_result/i_alu_valid/i_alu_ready             alu response
//   o_done/o_done_rd/o_done_data                     retire report
//
// Handshake
//   A request transfers on a rising edge where i_req_valid && o_req_ready.
//   o_req_ready is high only in IDLE and never during reset; the requester
//   may change or drop the request fields freely after the transfer edge.
//
// Configuration macro
//   ALU_ISSUE_R0_ZERO_EN : when defined, register 0 always reads 0 and every
//                          write to it (capture or external load) is dropped.
//                          o_done still reports the raw alu result.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_issue #(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_req_cmd,
  input  logic [ADDR_W-1:0] i_req_rs1,
  input  logic [ADDR_W-1:0] i_req_rs2,
  input  logic [ADDR_W-1:0] i_req_rd,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  output logic [31:0]       o_alu_a,
  output logic [31:0]       o_alu_b,
  output logic [2:0]        o_alu_cmd,
  input  logic [31:0]       i_alu_result,
  input  logic              i_alu_valid,
  input  logic              i_alu_ready,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_done_rd,
  output logic [31:0]       o_done_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] CMD_NOP = 3'd0;

  state_t            state;
  logic [ADDR_W-1:0] op_rd;
  logic [31:0]       regs [NREGS];

  // Register-file read port with the optional hard-wired zero in r0.
  function automatic logic [31:0] reg_read(input logic [ADDR_W-1:0] idx);
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (idx == '0) return 32'd0;
`endif
    return regs[idx];
  endfunction

  // True when a write to this index is allowed to land.
  function automatic logic reg_writable(input logic [ADDR_W-1:0] idx);
`ifdef ALU_ISSUE_R0_ZERO_EN
    return (idx != '0);
`else
    return (idx == idx);
`endif
  endfunction

  assign o_req_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset aborts any op in flight: no writeback, no done pulse.
      state       <= IDLE;
      op_rd       <= '0;
      o_alu_a     <= 32'd0;
      o_alu_b     <= 32'd0;
      o_alu_cmd   <= CMD_NOP;
      o_done      <= 1'b0;
      o_done_rd   <= '0;
      o_done_data <= 32'd0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 32'd0;
      end
    end else begin
      o_done <= 1'b0;

      // External load lands in any state. A capture to the same index later
      // in this block overrides it, so capture wins the collision.
      if (i_wr_en && reg_writable(i_wr_addr)) begin
        regs[i_wr_addr] <= i_wr_data;
      end

      case (state)
        IDLE: begin
          // Operands are sampled from the pre-edge register contents, so a
          // same-cycle external load to rs1/rs2 is not seen by this op.
          if (i_req_valid) begin
            o_alu_a   <= reg_read(i_req_rs1);
            o_alu_b   <= reg_read(i_req_rs2);
            o_alu_cmd <= i_req_cmd;
            op_rd     <= i_req_rd;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          // The alu samples its inputs on this edge when it is ready.
          if (i_alu_ready) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          // i_alu_valid is sticky in the alu and may still reflect an older
          // result; only valid together with ready marks the new one.
          if (i_alu_ready && i_alu_valid) begin
            if (reg_writable(op_rd)) begin
              regs[op_rd] <= i_alu_result;
            end
            o_done      <= 1'b1;
            o_done_rd   <= op_rd;
            o_done_data <= i_alu_result;
            o_alu_a     <= 32'd0;
            o_alu_b     <= 32'd0;
            o_alu_cmd   <= CMD_NOP;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
